pa_reg_file: RTL and testbench

//  Register file consuming the 4-bit play-area register address {pa, lower_reg_addr} from the decode stage.

---
 rtl/roe_pkg.sv | 23 ++
 rtl/pa_clr_seq.sv | 86 ++++++++
 rtl/pa_reg_file.sv | 81 ++++++++
 tb/tb_pa_reg_file.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/roe_pkg.sv
// ---------------------------------------------------------------------------
// roe_pkg
// Shared constants and types for the R.O.E operand register file.
//   REG_W      data width of one register
//   REG_AW     register address width (16 registers)
//   PA_W       play-area (bank) field width, upper bits of a register address
//   BANK_SIZE  registers per play-area bank
//   clr_state_t  states of the bank-clear sequencer
// ---------------------------------------------------------------------------
package roe_pkg;

  localparam int REG_W     = 8;
  localparam int REG_AW    = 4;
  localparam int PA_W      = 2;
  localparam int BANK_SIZE = 4;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clr_state_t;

endpackage

// File: rtl/pa_clr_seq.sv
// ---------------------------------------------------------------------------
// pa_clr_seq
// Bank-clear sequencer. On an accepted request it walks every register of one
// play-area bank, one register per cycle, then pulses done for one cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_req      clear request, only accepted while idle
//   clr_bank     bank to clear, captured together with an accepted request
//   clr_we       clear write strobe toward the storage array
//   clr_addr     register being cleared this cycle, {bank, idx}
//   clr_busy     high while clear writes are in progress
//   clr_done     one-cycle pulse after the final clear write
// ---------------------------------------------------------------------------
module pa_clr_seq #(
  parameter int AW        = roe_pkg::REG_AW,
  parameter int BANK_SIZE = roe_pkg::BANK_SIZE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr_req,
  input  logic [AW-$clog2(BANK_SIZE)-1:0] clr_bank,
  output logic                            clr_we,
  output logic [AW-1:0]                   clr_addr,
  output logic                            clr_busy,
  output logic                            clr_done
);
  import roe_pkg::*;

  localparam int IW = $clog2(BANK_SIZE);
  localparam int BW = AW - IW;
  localparam logic [IW-1:0] LP_LAST_IDX = IW'(BANK_SIZE - 1);

  clr_state_t      r_state;
  clr_state_t      w_state_next;
  logic [BW-1:0]   r_bank;
  logic [IW-1:0]   r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_IDLE;
      r_bank  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLR_IDLE && clr_req) begin
        r_bank <= clr_bank;
        r_idx  <= '0;
      end else if (r_state == CLR_RUN) begin
        // Wraps back to 0 on the final clear write, exactly when the state leaves RUN.
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    clr_we       = 1'b0;
    clr_busy     = 1'b0;
    clr_done     = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (clr_req) begin
          w_state_next = CLR_RUN;
        end
      end
      CLR_RUN: begin
        clr_we   = 1'b1;
        clr_busy = 1'b1;
        if (r_idx == LP_LAST_IDX) begin
          w_state_next = CLR_DONE;
        end
      end
      CLR_DONE: begin
        // Requests seen here are dropped; the next one is taken in IDLE.
        clr_done     = 1'b1;
        w_state_next = CLR_IDLE;
      end
      default: begin
        w_state_next = CLR_IDLE;
      end
    endcase
  end

  assign clr_addr = {r_bank, r_idx};

endmodule

// File: rtl/pa_reg_file.sv
// ---------------------------------------------------------------------------
// pa_reg_file
// Play-area register file between operand decode and the ALU.
// Two combinational read ports with write-to-read bypass, one synchronous
// write port, and a bank-clear sequencer that zeroes one play-area bank.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rd_addr_a / rd_data_a   read port A
//   rd_addr_b / rd_data_b   read port B
//   wr_en, wr_addr, wr_data write port, sampled at the rising edge
//   clr_req, clr_bank       bank-clear request and bank number
//   clr_busy, clr_done      clear in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module pa_reg_file #(
  parameter int W         = roe_pkg::REG_W,
  parameter int AW        = roe_pkg::REG_AW,
  parameter int BANK_SIZE = roe_pkg::BANK_SIZE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [AW-1:0]                   rd_addr_a,
  output logic [W-1:0]                    rd_data_a,
  input  logic [AW-1:0]                   rd_addr_b,
  output logic [W-1:0]                    rd_data_b,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [W-1:0]                    wr_data,
  input  logic                            clr_req,
  input  logic [AW-$clog2(BANK_SIZE)-1:0] clr_bank,
  output logic                            clr_busy,
  output logic                            clr_done
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0][W-1:0] r_regs;
  logic [NREG-1:0][W-1:0] w_regs_next;
  logic                   w_clr_we;
  logic [AW-1:0]          w_clr_addr;

  pa_clr_seq #(
    .AW        (AW),
    .BANK_SIZE (BANK_SIZE)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_bank (clr_bank),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // Per-register next value: the port write outranks a clear write aimed at
  // the same register; the clear sequencer keeps advancing regardless.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [AW-1:0] LP_ADDR = AW'(gi);
      logic w_port_hit;
      logic w_clr_hit;
      assign w_port_hit = wr_en && (wr_addr == LP_ADDR);
      assign w_clr_hit  = w_clr_we && (w_clr_addr == LP_ADDR);
      assign w_regs_next[gi] = w_port_hit ? wr_data :
                               w_clr_hit  ? '0      : r_regs[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      r_regs <= w_regs_next;
    end
  end

  // Only port writes are forwarded; a cleared register reads 0 from the next cycle.
  assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : r_regs[rd_addr_a];
  assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : r_regs[rd_addr_b];

endmodule

// File: tb/tb_pa_reg_file.sv
module tb_pa_reg_file;

  logic       clk;
  logic       rst_n;
  logic [3:0] rd_addr_a;
  logic [7:0] rd_data_a;
  logic [3:0] rd_addr_b;
  logic [7:0] rd_data_b;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_req;
  logic [1:0] clr_bank;
  logic       clr_busy;
  logic       clr_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mdl[16];
  logic [7:0] got;
  logic [7:0] exp;

  pa_reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_bank  (clr_bank),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port write lasting one clock edge; returns at the following negedge.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back(8'h00);
    got = {6'd0, clr_busy, clr_done}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_flags got %h exp %h", got, exp); end
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = a[3:0]; rd_addr_b = 4'(15 - a);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      #1;
      got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_rd_a r%0d got %h exp %h", a, got, exp); end
      got = rd_data_b; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_rd_b r%0d got %h exp %h", 15 - a, got, exp); end
    end
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset checks done");
  endtask

  task automatic test_write_read();
    rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    exp_q.push_back(8'h00);
    #1;
    got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pre_write_r5 got %h exp %h", got, exp); end
    rd_addr_b = 4'd6;
    do_write(4'd5, 8'h3C);
    rd_addr_b = 4'd5;
    exp_q.push_back(mdl[5]); exp_q.push_back(mdl[5]);
    #1;
    got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL write_r5_a got %h exp %h", got, exp); end
    got = rd_data_b; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL write_r5_b got %h exp %h", got, exp); end
    $display("[TB] write r5=3C, read back %h", rd_data_a);
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'hA5;
    rd_addr_a = 4'd9; rd_addr_b = 4'd9;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    #1;
    got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_a got %h exp %h", got, exp); end
    got = rd_data_b; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_b got %h exp %h", got, exp); end
    // Non-matching port must see the stored value, not the in-flight write.
    rd_addr_b = 4'd5;
    exp_q.push_back(mdl[5]);
    #1;
    got = rd_data_b; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_other got %h exp %h", got, exp); end
    @(negedge clk);
    wr_en = 1'b0; mdl[9] = 8'hA5;
    rd_addr_b = 4'd9;
    exp_q.push_back(mdl[9]);
    #1;
    got = rd_data_b; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL stored_r9 got %h exp %h", got, exp); end
    $display("[TB] bypass r9 checked");
  endtask

  task automatic test_bank_clear();
    for (int a = 7; a <= 12; a++) do_write(a[3:0], 8'hFF);
    clr_req = 1'b1; clr_bank = 2'd2;
    @(negedge clk);
    clr_req = 1'b0;
    // Clear is not bypassed: r8 still holds FF during its clear cycle.
    rd_addr_a = 4'd8;
    exp_q.push_back(8'hFF);
    #1;
    got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL clr_no_bypass got %h exp %h", got, exp); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_q.push_back((c < 4) ? 8'h02 : (c == 4) ? 8'h01 : 8'h00);
      got = {6'd0, clr_busy, clr_done}; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL clr_flags cyc%0d got %h exp %h", c, got, exp); end
      if (c == 1) begin
        exp_q.push_back(8'h00);
        got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL clr_r8_early got %h exp %h", got, exp); end
      end
    end
    for (int a = 8; a <= 11; a++) mdl[a] = 8'h00;
    for (int a = 7; a <= 12; a++) begin
      rd_addr_a = a[3:0];
      exp_q.push_back(mdl[a]);
      #1;
      got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL clr_bank2 r%0d got %h exp %h", a, got, exp); end
    end
    $display("[TB] bank 2 clear checked");
  endtask

  task automatic test_clear_collision();
    int ndone;
    for (int a = 4; a <= 7; a++) do_write(a[3:0], 8'h11);
    ndone = 0;
    clr_req = 1'b1; clr_bank = 2'd1;
    @(negedge clk);                 // idx 0 cycle
    clr_req = 1'b0;
    if (clr_done) ndone++;
    @(negedge clk);                 // idx 1 cycle: stray request and unrelated write
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h42;
    if (clr_done) ndone++;
    @(negedge clk);                 // idx 2 cycle: collide on r6
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h77;
    mdl[13] = 8'h42;
    if (clr_done) ndone++;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[6] = 8'h77; mdl[4] = 8'h00; mdl[5] = 8'h00; mdl[7] = 8'h00;
    for (int c = 0; c < 10; c++) begin
      if (clr_done) ndone++;
      @(negedge clk);
    end
    exp_q.push_back(8'd1);
    got = 8'(ndone); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL clr_done_count got %0d exp %0d", got, exp); end
    for (int a = 4; a <= 7; a++) begin
      rd_addr_a = a[3:0]; rd_addr_b = 4'd13;
      exp_q.push_back(mdl[a]); exp_q.push_back(mdl[13]);
      #1;
      got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL collide r%0d got %h exp %h", a, got, exp); end
      got = rd_data_b; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL during_clr_r13 got %h exp %h", got, exp); end
    end
    $display("[TB] collision clear checked");
  endtask

  task automatic test_reset_mid_clear();
    int ndone;
    do_write(4'd14, 8'h5A);
    clr_req = 1'b1; clr_bank = 2'd3;
    @(negedge clk);                 // 1st clear cycle
    clr_req = 1'b0;
    @(negedge clk);                 // 2nd clear cycle
    rst_n = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    got = {6'd0, clr_busy, clr_done}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_flags got %h exp %h", got, exp); end
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = a[3:0];
      exp_q.push_back(mdl[a]);
      #1;
      got = rd_data_a; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_mid r%0d got %h exp %h", a, got, exp); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (clr_done || clr_busy) ndone++;
    end
    exp_q.push_back(8'd0);
    got = 8'(ndone); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_activity got %0d exp %0d", got, exp); end
    $display("[TB] reset mid-clear checked");
  endtask

  task automatic test_back_to_back();
    int run;
    int ndone;
    run = 0; ndone = 0;
    clr_req = 1'b1; clr_bank = 2'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (clr_busy && clr_done) begin
        n_fail++; $display("FAIL b2b_overlap cyc%0d busy %b done %b", c, clr_busy, clr_done);
      end
      if (clr_busy) run++;
      if (clr_done) begin
        exp_q.push_back(8'd4);
        got = 8'(run); exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_busy_len got %0d exp %0d", got, exp); end
        run = 0; ndone++;
      end
    end
    clr_req = 1'b0;
    n_tests++;
    if (ndone < 3) begin n_fail++; $display("FAIL b2b_repeats got %0d exp >=3", ndone); end
    repeat (8) @(negedge clk);
    $display("[TB] back-to-back clears: %0d done pulses", ndone);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; clr_bank = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_bank_clear();
    test_clear_collision();
    test_reset_mid_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
